request_unit: RTL
=================

Name: request_unit

Overview:
- Fetch/memory sequencer between the instruction/data cache ports and the control unit.
- Issues instruction reads and latches the returned word into an instruction register that drives the control unit's `instruction` input.
- Turns the control unit's decoded `dREN`/`dWEN`/halt outputs into held data-memory requests, and produces the single-cycle `pc_en` advance strobe.
- Counts stall cycles for performance debug.

Parameters:
- WORD_W, 32, instruction/data word width
- STALL_CNT_W, 16, width of the saturating stall counter

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- imemload  input  WORD_W  instruction word from I-cache
- ihit  input  1  I-cache read complete this cycle
- dhit  input  1  D-cache read/write complete this cycle
- cu_dREN  input  1  control unit: current instruction reads data memory
- cu_dWEN  input  1  control unit: current instruction writes data memory
- cu_halt  input  1  control unit: current instruction is HALT
- imemREN  output  1  instruction read request to I-cache
- dmemREN  output  1  data read request to D-cache
- dmemWEN  output  1  data write request to D-cache
- instruction  output  WORD_W  latched instruction to control unit
- instr_valid  output  1  instruction register holds a fetched, not-yet-retired word
- pc_en  output  1  one-cycle PC advance strobe
- halt  output  1  sticky processor halt
- stall_cycles  output  STALL_CNT_W  saturating count of cycles spent waiting on ihit/dhit

Behaviour:
- Reset (nRST low, async), all outputs cleared:
  - state=FETCH, instruction=0, instr_valid=0, halt=0, stall_cycles=0
  - dmemREN=dmemWEN=0, pc_en=0
  - imemREN=1 (combinational in FETCH)
- State register: FETCH, EXEC, MEM, HALTED. All registered updates on rising CLK.
- FETCH:
  - imemREN=1.
  - No ihit: stall_cycles+1 (saturating), remain.
  - ihit: instruction<=imemload, instr_valid<=1, next EXEC.
- EXEC:
  - Control unit decodes `instruction` combinationally; request unit samples cu_* this cycle.
  - Priority 1, cu_halt=1: next HALTED, pc_en=0, halt<=1.
  - Priority 2, cu_dREN|cu_dWEN: latch rd_q<=cu_dREN&~cu_dWEN and wr_q<=cu_dWEN; next MEM; pc_en=0.
  - Otherwise: pc_en=1 (combinational, this cycle only), instr_valid<=0, next FETCH.
- MEM:
  - dmemREN=rd_q, dmemWEN=wr_q, held stable until dhit.
  - No dhit: stall_cycles+1 (saturating).
  - dhit: pc_en=1 this cycle, instr_valid<=0, rd_q/wr_q<=0, next FETCH.
- HALTED:
  - All requests 0, pc_en=0, halt=1.
  - Remains until nRST; ihit/dhit ignored.
- Latency:
  - Non-memory instruction: exactly 1 cycle after ihit to pc_en.
  - Memory instruction: pc_en in the dhit cycle.
  - Minimum 2 cycles per instruction with zero-wait caches.
- Boundary conditions:
  - ihit outside FETCH and dhit outside MEM are ignored; no state or counter change.
  - ihit and dhit in the same cycle: only the one matching the current state acts.
  - cu_dREN and cu_dWEN both 1: illegal decode; write wins, read dropped.
  - instruction register is stable from the ihit edge until the next FETCH's ihit. It is never overwritten in EXEC/MEM.
  - stall_cycles saturates at all-ones; never wraps.
  - Reset mid-MEM: requests drop asynchronously. No partial state survives.
  - pc_en never asserts in the same cycle as imemREN.

Decomposition:
- cpu_types_pkg additions:
  - reqstate_t enum {FETCH, EXEC, MEM, HALTED}, 2-bit
  - word_t (existing)
- New interface request_unit_if, with modports `ru` and `tb`, mirroring the control-unit interface style.
- One natural sub-module: sat_counter, parameterized by width, with inc enable and async clear. Used for stall_cycles.

Test Plan:
- Reset release, ihit=1 with imemload=32'h2001_0005 (ADDI), cu_* all 0 → instruction=32'h20010005 next cycle, instr_valid=1; pc_en=1 one cycle later; back in FETCH with imemREN=1.
- LW: ihit, then cu_dREN=1; dhit held low 3 cycles, then 1 → dmemREN=1 for 4 cycles, pc_en=1 only in the dhit cycle, stall_cycles=3.
- SW with cu_dREN=cu_dWEN=1 → dmemWEN=1, dmemREN=0 throughout MEM.
- HALT (imemload=32'hFFFF_FFFF, cu_halt=1) → halt=1 sticky; imemREN/dmem*/pc_en stay 0 for 10 cycles while ihit/dhit are toggled.
- Spurious dhit in FETCH and ihit in MEM → no transitions; instruction unchanged; stall_cycles still increments.
- Assert nRST low mid-MEM (dmemREN=1) → dmemREN drops without waiting for CLK. With STALL_CNT_W=4 and ihit held low 20 cycles, stall_cycles=4'hF and holds.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the request unit's sequencing states.
package cpu_types_pkg;

  localparam int WORD_WIDTH = 32;

  typedef logic [WORD_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    MEM    = 2'd2,
    HALTED = 2'd3
  } reqstate_t;

endpackage

// File: rtl/request_unit_if.sv
// Bundle of request-unit signals, laid out like the control-unit interface.
interface request_unit_if
  import cpu_types_pkg::*;
#(
  parameter int STALL_CNT_W = 16
);

  word_t                  imemload;
  logic                   ihit;
  logic                   dhit;
  logic                   cu_dREN;
  logic                   cu_dWEN;
  logic                   cu_halt;
  logic                   imemREN;
  logic                   dmemREN;
  logic                   dmemWEN;
  word_t                  instruction;
  logic                   instr_valid;
  logic                   pc_en;
  logic                   halt;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport ru (
    input  imemload, ihit, dhit, cu_dREN, cu_dWEN, cu_halt,
    output imemREN, dmemREN, dmemWEN, instruction, instr_valid, pc_en, halt, stall_cycles
  );

  modport tb (
    output imemload, ihit, dhit, cu_dREN, cu_dWEN, cu_halt,
    input  imemREN, dmemREN, dmemWEN, instruction, instr_valid, pc_en, halt, stall_cycles
  );

endinterface

// File: rtl/request_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; cleared only by reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic at_max;

  assign at_max = &count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/request_unit.sv
// Fetch/memory sequencer: fetches into the instruction register, turns decoded
// memory/halt requests into held cache requests, and strobes pc_en on retire.
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int WORD_W      = WORD_WIDTH,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [WORD_W-1:0]      imemload,
  input  logic                   ihit,
  input  logic                   dhit,
  input  logic                   cu_dREN,
  input  logic                   cu_dWEN,
  input  logic                   cu_halt,
  output logic                   imemREN,
  output logic                   dmemREN,
  output logic                   dmemWEN,
  output logic [WORD_W-1:0]      instruction,
  output logic                   instr_valid,
  output logic                   pc_en,
  output logic                   halt,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  reqstate_t state_q;
  reqstate_t state_d;

  logic rd_q;
  logic wr_q;
  logic load_instr;
  logic latch_mem;
  logic retire;
  logic go_halt;
  logic stall_inc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Each state only listens to its own handshake, so stray ihit/dhit are ignored.
  always_comb begin
    state_d    = state_q;
    imemREN    = 1'b0;
    pc_en      = 1'b0;
    load_instr = 1'b0;
    latch_mem  = 1'b0;
    retire     = 1'b0;
    go_halt    = 1'b0;
    stall_inc  = 1'b0;

    case (state_q)
      FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          load_instr = 1'b1;
          state_d    = EXEC;
        end else begin
          stall_inc = 1'b1;
        end
      end

      EXEC: begin
        if (cu_halt) begin
          go_halt = 1'b1;
          state_d = HALTED;
        end else if (cu_dREN || cu_dWEN) begin
          latch_mem = 1'b1;
          state_d   = MEM;
        end else begin
          pc_en   = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
        end
      end

      MEM: begin
        if (dhit) begin
          pc_en   = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
        end else begin
          stall_inc = 1'b1;
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instruction <= '0;
      instr_valid <= 1'b0;
    end else if (load_instr) begin
      instruction <= imemload;
      instr_valid <= 1'b1;
    end else if (retire) begin
      instr_valid <= 1'b0;
    end
  end

  // A read+write decode is illegal; the write is kept and the read dropped.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else if (latch_mem) begin
      rd_q <= cu_dREN & ~cu_dWEN;
      wr_q <= cu_dWEN;
    end else if (retire) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halt <= 1'b0;
    end else if (go_halt) begin
      halt <= 1'b1;
    end
  end

  // Gating with the state keeps the requests tied to the async-reset state register.
  assign dmemREN = (state_q == MEM) && rd_q;
  assign dmemWEN = (state_q == MEM) && wr_q;

  sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

endmodule
